// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer between a combinational-read imem and decode.
// Owns the fetch PC, drives the imem byte address, and buffers {pc, inst} pairs in a
// small prefetch FIFO that decode drains with a valid/ready handshake. Supports
// start, halt/resume and redirects (flush + reload of the fetch PC).
//
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   - a redirect to a non-word-aligned target flushes, loads the target,
//               raises misalign and halts; misalign clears on an aligned redirect
//   undefined - redirect targets are word-aligned by masking bits [1:0]; misalign is 0
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               leave IDLE and begin fetching
//   halt_req, resume    enter / leave HALTED (halt_req wins)
//   redirect,
//   redirect_pc         flush the FIFO and load a new fetch target
//   imem_pc, imem_inst  imem byte address out, instruction word back the same cycle
//   if_valid, if_inst,
//   if_pc, id_ready     FIFO head towards decode
//   halted              state is HALTED
//   fifo_level          current FIFO entry count
//   misalign            misaligned redirect trapped (trap build only)
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned IMEM_AW    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        halt_req,
    input  logic                        resume,
    input  logic                        redirect,
    input  logic [31:0]                 redirect_pc,
    output logic [31:0]                 imem_pc,
    input  logic [31:0]                 imem_inst,
    output logic                        if_valid,
    output logic [31:0]                 if_inst,
    output logic [31:0]                 if_pc,
    input  logic                        id_ready,
    output logic                        halted,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        misalign
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   mem_pc   [FIFO_DEPTH];
    logic [31:0]   mem_inst [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          trap;
    logic [31:0]   redir_target;

    // imem sees only the low IMEM_AW address bits; upper bits forced to zero
    assign imem_pc = 32'(fetch_pc[IMEM_AW-1:0]);

    assign if_valid = (fifo_level != '0);
    assign if_pc    = mem_pc[rd_ptr];
    assign if_inst  = mem_inst[rd_ptr];

    // A redirect discards any pop in the same cycle; push-with-pop is allowed when full
    assign pop  = if_valid && id_ready && !redirect;
    assign push = (state == S_FETCH) && !redirect &&
                  ((fifo_level < LW'(FIFO_DEPTH)) || pop);

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign trap         = redirect && (redirect_pc[1:0] != 2'b00);
    assign redir_target = redirect_pc;

    // Sticky misalign flag, cleared only by an aligned redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (redirect) begin
            misalign <= trap;
        end
    end
`else
    assign trap         = 1'b0;
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
    assign misalign     = 1'b0;
`endif

    // Control FSM and fetch PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            halted   <= 1'b0;
            fetch_pc <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= redir_target;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (trap) begin
                state  <= S_HALTED;
                halted <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (halt_req) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end
                    end
                    S_HALTED: begin
                        if (resume && !halt_req && !misalign) begin
                            state  <= S_FETCH;
                            halted <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        halted <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Prefetch FIFO; redirect flushes and overrides push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pc     <= '{default: '0};
            mem_inst   <= '{default: '0};
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]   <= fetch_pc;
                mem_inst[wr_ptr] <= imem_inst;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

endmodule
